// File: rtl/addcmp_sched.sv
// Round-robin scheduler sharing one AddCmp50 (a+b==c mod 2^50) among NREQ requesters.
// Two-stage pipeline: S1 operand register feeding the compare, S2 result register.

module AddCmp50 (
  input  logic [49:0] a,
  input  logic [49:0] b,
  input  logic [49:0] c,
  output logic        eq
);
  logic [49:0] sum;

  assign sum = a + b;
  assign eq  = (sum == c);
endmodule

module addcmp_sched #(
  parameter  int NREQ = 4,
  parameter  int TAGW = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*50-1:0]   req_a,
  input  logic [NREQ*50-1:0]   req_b,
  input  logic [NREQ*50-1:0]   req_c,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_eq,
  output logic [IDW-1:0]       rsp_id,
  output logic [TAGW-1:0]      rsp_tag,
  output logic                 busy
);

  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;
  logic [49:0]     sel_a, sel_b, sel_c;
  logic [TAGW-1:0] sel_tag;

  logic            s1_vld, s2_vld;
  logic            s1_take, s2_adv, accept;
  logic [49:0]     s1_a, s1_b, s1_c;
  logic [IDW-1:0]  s1_id, s2_id;
  logic [TAGW-1:0] s1_tag, s2_tag;
  logic            s2_eq, cmp_eq;

  // Two passes give the round-robin order ptr..NREQ-1 then 0..ptr-1 without modulo arithmetic.
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    sel_a   = '0;
    sel_b   = '0;
    sel_c   = '0;
    sel_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_any && req_valid[i] && (IDW'(i) >= ptr)) begin
        gnt_any  = 1'b1;
        grant[i] = 1'b1;
        gnt_id   = IDW'(i);
        sel_a    = req_a[i*50 +: 50];
        sel_b    = req_b[i*50 +: 50];
        sel_c    = req_c[i*50 +: 50];
        sel_tag  = req_tag[i*TAGW +: TAGW];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_any && req_valid[i] && (IDW'(i) < ptr)) begin
        gnt_any  = 1'b1;
        grant[i] = 1'b1;
        gnt_id   = IDW'(i);
        sel_a    = req_a[i*50 +: 50];
        sel_b    = req_b[i*50 +: 50];
        sel_c    = req_c[i*50 +: 50];
        sel_tag  = req_tag[i*TAGW +: TAGW];
      end
    end
  end

  assign s2_adv    = s1_vld & (~s2_vld | rsp_ready);
  assign s1_take   = ~s1_vld | s2_adv;
  // rst_n gating keeps req_ready low for the whole reset, not just after the first edge.
  assign accept    = gnt_any & s1_take & rst_n;
  assign req_ready = grant & {NREQ{s1_take & rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      ptr    <= '0;
    end else begin
      if (s1_take)
        s1_vld <= accept;
      if (s2_adv)
        s2_vld <= 1'b1;
      else if (rsp_ready)
        s2_vld <= 1'b0;
      if (accept)
        ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Payload registers need no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a   <= sel_a;
      s1_b   <= sel_b;
      s1_c   <= sel_c;
      s1_id  <= gnt_id;
      s1_tag <= sel_tag;
    end
    if (s2_adv) begin
      s2_eq  <= cmp_eq;
      s2_id  <= s1_id;
      s2_tag <= s1_tag;
    end
  end

  AddCmp50 u_cmp (
    .a  (s1_a),
    .b  (s1_b),
    .c  (s1_c),
    .eq (cmp_eq)
  );

  assign rsp_valid = s2_vld;
  assign rsp_eq    = s2_eq;
  assign rsp_id    = s2_id;
  assign rsp_tag   = s2_tag;
  assign busy      = s1_vld | s2_vld;

endmodule

// File: tb/tb_addcmp_sched.sv
// Directed self-checking bench for addcmp_sched: latency, round-robin order,
// modulo arithmetic, backpressure, fairness and asynchronous reset.

module tb_addcmp_sched;

  localparam int NREQ = 4;
  localparam int TAGW = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*50-1:0]   req_a, req_b, req_c;
  logic [NREQ*TAGW-1:0] req_tag;
  logic                 rsp_valid, rsp_ready, rsp_eq, busy;
  logic [IDW-1:0]       rsp_id;
  logic [TAGW-1:0]      rsp_tag;

  int checks   = 0;
  int failures = 0;

  addcmp_sched #(.NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_eq    (rsp_eq),
    .rsp_id    (rsp_id),
    .rsp_tag   (rsp_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Requester-side protocol: a pending request must stay valid with a stable payload.
  logic [NREQ-1:0]      pend;
  logic [NREQ*50-1:0]   hold_a, hold_b, hold_c;
  logic [NREQ*TAGW-1:0] hold_tag;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i]) begin
          checks++;
          if (req_valid[i] !== 1'b1 || req_a[i*50 +: 50] !== hold_a[i*50 +: 50] ||
              req_b[i*50 +: 50] !== hold_b[i*50 +: 50] || req_c[i*50 +: 50] !== hold_c[i*50 +: 50] ||
              req_tag[i*TAGW +: TAGW] !== hold_tag[i*TAGW +: TAGW]) begin
            failures++;
            $display("[TB] FAIL handshake_hold req %0d: got valid %b tag %0h, expected valid 1 tag %0h",
                     i, req_valid[i], req_tag[i*TAGW +: TAGW], hold_tag[i*TAGW +: TAGW]);
          end
        end
      end
      pend     <= req_valid & ~req_ready;
      hold_a   <= req_a;
      hold_b   <= req_b;
      hold_c   <= req_c;
      hold_tag <= req_tag;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic set_req(input int i, input logic [49:0] a, input logic [49:0] b,
                         input logic [49:0] c, input logic [TAGW-1:0] tag);
    req_a[i*50 +: 50]       = a;
    req_b[i*50 +: 50]       = b;
    req_c[i*50 +: 50]       = c;
    req_tag[i*TAGW +: TAGW] = tag;
  endtask

  // Leaves rst_n released on a falling edge so the next rising edge is the first active one.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got ready %b valid %b busy %b, expected 0000 0 0", req_ready, rsp_valid, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_held: got ready %b valid %b busy %b, expected 0000 0 0", req_ready, rsp_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release_grant: got ready %b busy %b, expected 0001 0", req_ready, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0010 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_first_accept: got ready %b busy %b valid %b, expected 0010 1 0", req_ready, busy, rsp_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 50'd5, 50'd7, 50'd12, 4'd3);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL single_ready: got %b, expected 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_early: got rsp_valid %b, expected 0", rsp_valid);
    end
    @(negedge clk);
    set_req(0, 50'd5, 50'd7, 50'd13, 4'd5);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_eq !== 1'b1 || rsp_id !== 2'd0 || rsp_tag !== 4'd3) begin
      failures++;
      $display("[TB] FAIL single_eq_rsp: got v%b eq%b id%0d tag%0h, expected v1 eq1 id0 tag3", rsp_valid, rsp_eq, rsp_id, rsp_tag);
    end
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL single_ready2: got %b, expected 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_early2: got rsp_valid %b, expected 0", rsp_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_eq !== 1'b0 || rsp_id !== 2'd0 || rsp_tag !== 4'd5) begin
      failures++;
      $display("[TB] FAIL single_ne_rsp: got v%b eq%b id%0d tag%0h, expected v1 eq0 id0 tag5", rsp_valid, rsp_eq, rsp_id, rsp_tag);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_rdy;
    int id;
    do_reset();
    for (int i = 0; i < NREQ; i++)
      set_req(i, 50'(i * 100), 50'(i), (i == 2) ? 50'd0 : 50'(i * 101), 4'(8 + i));
    req_valid = 4'b1111;
    for (int n = 0; n < 10; n++) begin
      if (n > 0) @(negedge clk);
      #1;
      exp_rdy = 4'(1 << (n % 4));
      checks++;
      if (req_ready !== exp_rdy) begin
        failures++;
        $display("[TB] FAIL b2b_grant cycle %0d: got %b, expected %b", n, req_ready, exp_rdy);
      end
      checks++;
      if (n >= 2) begin
        id = (n - 2) % 4;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(id) || rsp_tag !== 4'(8 + id) || rsp_eq !== (id != 2)) begin
          failures++;
          $display("[TB] FAIL b2b_rsp cycle %0d: got v%b id%0d tag%0h eq%b, expected v1 id%0d tag%0h eq%b",
                   n, rsp_valid, rsp_id, rsp_tag, rsp_eq, id, 8 + id, id != 2);
        end
      end else if (rsp_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL b2b_fill cycle %0d: got rsp_valid %b, expected 0", n, rsp_valid);
      end
    end
  endtask

  task automatic test_wrap();
    logic [49:0] wa[3];
    logic [49:0] wb[3];
    logic [49:0] wc[3];
    logic        we[3];
    wa[0] = 50'h3FFFFFFFFFFFF; wb[0] = 50'd1;           wc[0] = 50'd0;           we[0] = 1'b1;
    wa[1] = 50'h2000000000000; wb[1] = 50'h2000000000000; wc[1] = 50'd0;         we[1] = 1'b1;
    wa[2] = 50'd0;             wb[2] = 50'd0;           wc[2] = 50'h3FFFFFFFFFFFF; we[2] = 1'b0;
    do_reset();
    for (int n = 0; n < 5; n++) begin
      if (n > 0) @(negedge clk);
      if (n < 3) begin
        set_req(1, wa[n], wb[n], wc[n], 4'(n + 1));
        req_valid = 4'b0010;
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      if (n < 3) begin
        checks++;
        if (req_ready !== 4'b0010) begin
          failures++;
          $display("[TB] FAIL wrap_ready cycle %0d: got %b, expected 0010", n, req_ready);
        end
      end
      if (n >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_eq !== we[n-2] || rsp_id !== 2'd1 || rsp_tag !== 4'(n - 1)) begin
          failures++;
          $display("[TB] FAIL wrap_rsp vec %0d: got v%b eq%b id%0d tag%0h, expected v1 eq%b id1 tag%0h",
                   n - 2, rsp_valid, rsp_eq, rsp_id, rsp_tag, we[n-2], n - 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int item_at[9]  = '{0, 1, 2, 2, 2, 2, -1, -1, -1};
    int rsp_at[9]   = '{-1, -1, 0, 0, 0, 0, 1, 2, -1};
    logic [3:0] rdy_at[9] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    int j;
    int r;
    do_reset();
    rsp_ready = 1'b0;
    for (int n = 0; n < 9; n++) begin
      if (n > 0) @(negedge clk);
      j = item_at[n];
      if (j >= 0) begin
        set_req(2, 50'(j + 10), 50'(j), (j == 1) ? 50'd0 : 50'(2 * j + 10), 4'(j + 4));
        req_valid = 4'b0100;
      end else begin
        req_valid = 4'b0000;
      end
      rsp_ready = (n >= 5);
      #1;
      checks++;
      if (req_ready !== rdy_at[n]) begin
        failures++;
        $display("[TB] FAIL bp_ready cycle %0d: got %b, expected %b", n, req_ready, rdy_at[n]);
      end
      r = rsp_at[n];
      checks++;
      if (r >= 0) begin
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_tag !== 4'(r + 4) || rsp_eq !== (r != 1)) begin
          failures++;
          $display("[TB] FAIL bp_rsp cycle %0d: got v%b id%0d tag%0h eq%b, expected v1 id2 tag%0h eq%b",
                   n, rsp_valid, rsp_id, rsp_tag, rsp_eq, r + 4, r != 1);
        end
      end else if (rsp_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_idle cycle %0d: got rsp_valid %b, expected 0", n, rsp_valid);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_drained: got busy %b, expected 0", busy);
    end
  endtask

  task automatic test_fairness();
    int g[7] = '{1, 3, 1, 3, 1, 1, 1};
    do_reset();
    set_req(1, 50'd1, 50'd1, 50'd2, 4'd1);
    set_req(3, 50'd3, 50'd3, 50'd6, 4'd3);
    req_valid = 4'b1010;
    for (int n = 0; n < 7; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 4) req_valid = 4'b0010;
      #1;
      checks++;
      if (req_ready !== 4'(1 << g[n])) begin
        failures++;
        $display("[TB] FAIL fair_grant cycle %0d: got %b, expected %b", n, req_ready, 4'(1 << g[n]));
      end
      if (n >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(g[n-2]) || rsp_tag !== 4'(g[n-2]) || rsp_eq !== 1'b1) begin
          failures++;
          $display("[TB] FAIL fair_rsp cycle %0d: got v%b id%0d tag%0h eq%b, expected v1 id%0d tag%0h eq1",
                   n, rsp_valid, rsp_id, rsp_tag, rsp_eq, g[n-2], g[n-2]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 50'd1, 50'd1, 50'd2, 4'd1);
    set_req(1, 50'd2, 50'd2, 50'd5, 4'd2);
    req_valid = 4'b0011;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL ar_grant0: got %b, expected 0001", req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("[TB] FAIL ar_grant1: got %b, expected 0010", req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 4'b0000 || rsp_tag !== 4'd1) begin
      failures++;
      $display("[TB] FAIL ar_full: got v%b busy%b ready%b tag%0h, expected v1 busy1 ready0000 tag1", rsp_valid, busy, req_ready, rsp_tag);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL ar_async_drop: got v%b busy%b ready%b, expected v0 busy0 ready0000", rsp_valid, busy, req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 50'd4, 50'd4, 50'd8, 4'd9);
    set_req(3, 50'd5, 50'd5, 50'd10, 4'd10);
    req_valid = 4'b1001;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ar_ptr_zero: got ready%b v%b busy%b, expected ready0001 v0 busy0", req_ready, rsp_valid, busy);
    end
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000 || rsp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ar_no_stale: got ready%b v%b, expected ready1000 v0", req_ready, rsp_valid);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_tag !== 4'd9 || rsp_eq !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ar_rsp0: got v%b id%0d tag%0h eq%b, expected v1 id0 tag9 eq1", rsp_valid, rsp_id, rsp_tag, rsp_eq);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_tag !== 4'd10 || rsp_eq !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ar_rsp3: got v%b id%0d tag%0h eq%b, expected v1 id3 tag%0h eq1", rsp_valid, rsp_id, rsp_tag, rsp_eq, 10);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ar_drained: got v%b busy%b, expected v0 busy0", rsp_valid, busy);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;
    $display("[TB] starting addcmp_sched tests");
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_backpressure();
    test_fairness();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
